// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch and data-access stages. Data requests win over fetches.
// Each access holds the port for LAT cycles, and one response cycle follows.
// The stall outputs hold the front pipeline while a request is outstanding.
// Optional build macro: MEM_ARB_POSTED_WRITE_EN. When it is defined, a store
// holds the port for a single cycle and completes without waiting for LAT.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stall_if_o,
  output logic              stall_all_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_RESP_I,
    S_RESP_D
  } state_e;

  localparam logic [3:0] LAT_CNT = 4'(LAT);
`ifdef MEM_ARB_POSTED_WRITE_EN
  localparam logic [3:0] WR_CNT = 4'd1;
`else
  localparam logic [3:0] WR_CNT = LAT_CNT;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              data_req;
  logic              last_cycle;

  assign data_req   = mem_read_i | mem_write_i;
  // cnt_q <= 1 also finishes the access if cnt_q were ever 0, so it cannot hang
  assign last_cycle = (cnt_q <= 4'd1);

  // State register and access registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Grant, latency countdown and read-data capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          // Read and write both high is treated as a write
          state_d = S_DATA;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          we_d    = mem_write_i;
          cnt_d   = mem_write_i ? WR_CNT : LAT_CNT;
        end else if (if_req_i) begin
          state_d = S_FETCH;
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          cnt_d   = LAT_CNT;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q - 4'd1;
        if (last_cycle) begin
          if_rdata_d = ram_rdata_i;
          state_d    = S_RESP_I;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q - 4'd1;
        if (last_cycle) begin
          if (!we_q) begin
            mem_rdata_d = ram_rdata_i;
          end
          state_d = S_RESP_D;
        end
      end
      // The requester's level is still high during the response cycle, so
      // no grant is made here
      S_RESP_I: state_d = S_IDLE;
      S_RESP_D: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ram_en_o    = (state_q == S_FETCH) | (state_q == S_DATA);
  assign ram_we_o    = ram_en_o & we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_valid_o  = (state_q == S_RESP_I);
  assign mem_done_o  = (state_q == S_RESP_D);
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign stall_all_o = data_req & (state_q != S_RESP_D);
  assign stall_if_o  = stall_all_o | (if_req_i & (state_q != S_RESP_I));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=3. The memory model returns
// valid data only in the LAT-th enabled cycle of an access.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
`ifdef MEM_ARB_POSTED_WRITE_EN
  localparam int WR_PULSE = 2;
  localparam int WR_CYC   = 1;
`else
  localparam int WR_PULSE = 4;
  localparam int WR_CYC   = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        if_valid, mem_done, stall_if, stall_all;
  logic [31:0] if_rdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
    .stall_if_o(stall_if), .stall_all_o(stall_all)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  mem_word = 32'h0000_1234;
      32'h44:  mem_word = 32'h0000_5678;
      32'h80:  mem_word = 32'h0000_BEEF;
      default: mem_word = 32'hDEAD_0000 ^ a;
    endcase
  endfunction

  // Count consecutive enabled cycles to model the memory's read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else        en_cnt <= ram_en ? en_cnt + 1 : 0;
  end

  assign ram_rdata = (ram_en && en_cnt == LAT - 1) ? mem_word(ram_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follow one access from the grant edge up to its response pulse
  task automatic run_access(input bit for_if, input logic [31:0] eaddr,
                            input logic [31:0] ewdata, output int t_pulse,
                            output int n_en, output int n_we, output int n_bad);
    t_pulse = -1; n_en = 0; n_we = 0; n_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ram_en) begin
        n_en++;
        if (ram_addr !== eaddr) n_bad++;
        if (ram_we) begin
          n_we++;
          if (ram_wdata !== ewdata) n_bad++;
        end
      end
      if (for_if ? mem_done : if_valid) n_bad++;
      if (for_if ? if_valid : mem_done) begin
        t_pulse = c;
        if ((for_if ? stall_if : stall_all) !== 1'b0) n_bad++;
        break;
      end else if ((for_if ? stall_if : stall_all) !== 1'b1) begin
        n_bad++;
      end
    end
  endtask

  int tp, ne, nw, nb;
  bit seen;

  initial begin
    // Reset state
    #2;
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_stall_all", stall_all, 0);
    check("rst_stall_if", stall_if, 0);
    if_req = 1'b1; #1;
    check("rst_stall_if_req", stall_if, 1);
    if_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch of 0x40
    if_req = 1'b1; if_addr = 32'h40; #1;
    check("f_idle_stall_if", stall_if, 1);
    run_access(1'b1, 32'h40, 32'h0, tp, ne, nw, nb);
    check("f_pulse_cycle", tp, 4);
    check("f_en_cycles", ne, 3);
    check("f_we_cycles", nw, 0);
    check("f_bad", nb, 0);
    check("f_rdata", if_rdata, 32'h1234);
    if_req = 1'b0;
    tick();
    check("f_pulse_one_cycle", if_valid, 0);

    // Simultaneous fetch and load: data first
    if_req = 1'b1; if_addr = 32'h44;
    mem_read = 1'b1; mem_addr = 32'h80; #1;
    check("s_idle_stall_all", stall_all, 1);
    run_access(1'b0, 32'h80, 32'h0, tp, ne, nw, nb);
    check("s_data_pulse", tp, 4);
    check("s_data_en", ne, 3);
    check("s_data_bad", nb, 0);
    check("s_mem_rdata", mem_rdata, 32'hBEEF);
    check("s_resp_stall_if", stall_if, 1);
    mem_read = 1'b0;
    tick();
    check("s_idle_no_en", ram_en, 0);
    check("s_idle_stall_if", stall_if, 1);
    run_access(1'b1, 32'h44, 32'h0, tp, ne, nw, nb);
    check("s_fetch_pulse", tp, 4);
    check("s_fetch_en", ne, 3);
    check("s_fetch_bad", nb, 0);
    check("s_if_rdata", if_rdata, 32'h5678);
    if_req = 1'b0;
    tick();

    // Store 0x55 to 0x10
    mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h55; #1;
    run_access(1'b0, 32'h10, 32'h55, tp, ne, nw, nb);
    check("w_pulse", tp, WR_PULSE);
    check("w_en", ne, WR_CYC);
    check("w_we", nw, WR_CYC);
    check("w_bad", nb, 0);
    check("w_mem_rdata_kept", mem_rdata, 32'hBEEF);
    mem_write = 1'b0;
    tick();

    // Read and write together act as a write
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h77; #1;
    run_access(1'b0, 32'h20, 32'h77, tp, ne, nw, nb);
    check("rw_pulse", tp, WR_PULSE);
    check("rw_we", nw, WR_CYC);
    check("rw_bad", nb, 0);
    check("rw_mem_rdata_kept", mem_rdata, 32'hBEEF);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();

    // Reset in the second fetch cycle
    if_req = 1'b1; if_addr = 32'h40;
    tick(); tick();
    check("r_en_before", ram_en, 1);
    rst_n = 1'b0; #1;
    check("r_en_dropped", ram_en, 0);
    check("r_if_rdata_clr", if_rdata, 0);
    tick();
    check("r_no_valid", if_valid, 0);
    rst_n = 1'b1;
    run_access(1'b1, 32'h40, 32'h0, tp, ne, nw, nb);
    check("r_regrant_pulse", tp, 4);
    check("r_regrant_bad", nb, 0);
    check("r_regrant_rdata", if_rdata, 32'h1234);
    if_req = 1'b0;
    tick();

    // Load held one cycle past its response
    mem_read = 1'b1; mem_addr = 32'h80; #1;
    run_access(1'b0, 32'h80, 32'h0, tp, ne, nw, nb);
    check("h_pulse", tp, 4);
    tick();
    check("h_no_regrant_in_resp", ram_en, 0);
    check("h_idle_done_low", mem_done, 0);
    tick();
    check("h_regrant_from_idle", ram_en, 1);
    mem_read = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (mem_done) seen = 1'b1;
    end
    check("h_dropped_completes", seen, 1);
    tick();
    tick();
    check("h_no_grant_after_drop", ram_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) stage and data-access (MEM) stage. It grants the port, sequences each multi-cycle access with a latency counter, returns read data, and drives the pipeline stall signals that hold PC/IF_ID or the whole front pipeline while an access is outstanding. It sits beside the hazard/forwarding logic, and its stalls are ORed with the load-use stall.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `LAT`, default 2: memory read latency in cycles, legal range 1..15.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-low.
- `if_req_i` in 1: IF stage wants an instruction at `if_addr_i`.
- `if_addr_i` in ADDR_W: fetch address.
- `mem_read_i` in 1: EX/MEM stage load request.
- `mem_write_i` in 1: EX/MEM stage store request.
- `mem_addr_i` in ADDR_W: data address.
- `mem_wdata_i` in DATA_W: store data.
- `ram_en_o` out 1: memory access enable.
- `ram_we_o` out 1: memory write enable.
- `ram_addr_o` out ADDR_W: address to memory.
- `ram_wdata_o` out DATA_W: write data to memory.
- `ram_rdata_i` in DATA_W: memory read data.
- `if_valid_o` out 1: one-cycle pulse; `if_rdata_o` holds the fetched instruction.
- `if_rdata_o` out DATA_W: fetched instruction.
- `mem_done_o` out 1: one-cycle pulse; data access complete and `mem_rdata_o` valid for a load.
- `mem_rdata_o` out DATA_W: load data.
- `stall_if_o` out 1: freeze PC and IF/ID.
- `stall_all_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - FETCH: instruction access in progress.
  - DATA: data access in progress.
  - RESP_I: one-cycle instruction response.
  - RESP_D: one-cycle data response.
- Grant in IDLE:
  - `mem_read_i|mem_write_i` has priority: go to DATA.
  - Otherwise `if_req_i`: go to FETCH.
  - Otherwise stay in IDLE.
  - `mem_read_i` and `mem_write_i` both high is treated as a write.
- On grant, register the address, write data and write flag. Load the counter `cnt` with `LAT`; `cnt` is 4 bits wide.
- In FETCH or DATA:
  - `ram_en_o=1`.
  - `ram_addr_o`, `ram_wdata_o` and `ram_we_o` come from the registered copies, so they stay stable for the whole access.
  - `cnt` decrements each cycle.
  - In the cycle where `cnt==1`, capture `ram_rdata_i` into `if_rdata_o` or `mem_rdata_o` and move to RESP_I or RESP_D.
- A write still occupies the port for LAT cycles. `mem_rdata_o` is unchanged on a write.
- RESP_I asserts `if_valid_o`; RESP_D asserts `mem_done_o`. No grant is made in RESP states, because the requester's level is still visible that cycle. The next state is always IDLE.
- Stall outputs (combinational):
  - `stall_all_o = (mem_read_i|mem_write_i) & (state!=RESP_D)`
  - `stall_if_o = stall_all_o | (if_req_i & state!=RESP_I)`
- Requests are levels. A requester holds its request and address until its response pulse. A request dropped mid-access does not abort the access; the response pulse still occurs and is ignored.
- If `if_req_i` and a data request arrive together in IDLE, the data access is served first, then the fetch starts no earlier than the IDLE cycle after RESP_D.

## Timing
- Reset (asynchronous, `rst_i=0`):
  - state=IDLE, cnt=0.
  - All outputs 0, except the stalls, which follow their equations with state=IDLE.
  - `if_rdata_o` and `mem_rdata_o` are 0.
- Reset mid-access aborts the access immediately: `ram_en_o` drops at reset assertion and no response pulse follows.
- Grant edge to first `ram_en_o` cycle: 1 cycle, with registered outputs.
- Request seen in IDLE to response pulse: LAT+1 cycles. Back-to-back throughput is one access per LAT+2 cycles.
- Memory contract: read data is valid in the LAT-th cycle of `ram_en_o` with a stable address. A write is committed on any enabled cycle with `ram_we_o=1`.

## Configuration
- `MEM_ARB_POSTED_WRITE_EN` defined: a write is captured and `mem_done_o` pulses without waiting.
  - Grant to DATA with write: `cnt` is loaded with 1, and `ram_en_o` and `ram_we_o` are high for exactly 1 cycle, followed by RESP_D.
  - Store response latency is 2 cycles regardless of LAT.
- Undefined: writes take the full LAT-cycle sequence, the same as reads.

## Test plan
- LAT=2, fetch only: `if_req_i=1`, `if_addr_i=0x40`, memory returns 0x1234 →
  - `ram_en_o` high for 2 cycles with `ram_addr_o=0x40`.
  - `if_valid_o` pulses 3 cycles after the request with `if_rdata_o=0x1234`.
  - `stall_if_o` is high for every request cycle except that pulse cycle.
- Simultaneous requests: `if_req_i` and `mem_read_i` (addr 0x80, data 0xBEEF) in the same cycle →
  - DATA is served first; `stall_all_o=1` until the `mem_done_o` cycle.
  - `mem_rdata_o=0xBEEF`.
  - FETCH starts in the IDLE cycle after RESP_D.
- Store with macro off, LAT=3: `mem_write_i=1`, addr 0x10, data 0x55 → `ram_we_o` high for 3 cycles at 0x10/0x55, `mem_done_o` at cycle 4, `mem_rdata_o` unchanged.
- Store with `MEM_ARB_POSTED_WRITE_EN`, LAT=3 → `ram_we_o` high for 1 cycle, `mem_done_o` at cycle 2.
- Reset mid-access: assert `rst_i=0` in the 2nd cycle of FETCH → `ram_en_o=0` immediately, no `if_valid_o`, and a fresh grant happens after release.
- Request held through response: `mem_read_i` held one cycle past `mem_done_o` while `state=RESP_D` → no re-grant in that cycle; the re-grant occurs from IDLE only if the request is still high there.
